// File: rtl/llc_bus_op_ctrl.sv
// rtl/llc_bus_op_ctrl.sv - LLC shared-bus operation issuer with HITM retry and snoop collection
//
// Purpose:
//   Accepts one cache request at a time (READ, WRITE, INVALIDATE, RWIM), drives
//   it on the shared bus with a line-aligned address, collects the snoop result
//   and returns a single one-cycle response. READ and RWIM that see HITM are
//   reissued after an idle gap, up to MAX_RETRY times, giving the owning cache
//   time to write its modified line back.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; req_op (0 RD,1 WR,2 INV,3 RWIM), req_addr
//   bus_valid/bus_ack   bus handshake; bus_op, bus_addr (line-aligned) held until ack
//   snoop_rslt          0 HIT, 1 HITM, 2 NOHIT, 3 reserved (treated as NOHIT)
//   rsp_valid           one-cycle completion pulse with rsp_snoop, rsp_retry_fail
//   cnt_ops, cnt_hitm   saturating bus_ack / HITM counters
//
// Configuration:
//   BUS_STATS_EN  when defined, cnt_ops/cnt_hitm are real counters; otherwise
//                 no counter state exists and both outputs read 0.

module llc_bus_op_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int LINE_OFF  = 6,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        snoop_rslt,
  output logic              rsp_valid,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_retry_fail,
  output logic [15:0]       cnt_ops,
  output logic [15:0]       cnt_hitm
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_RWIM  = 2'd3;
  localparam logic [1:0] SN_HITM  = 2'd1;
  localparam logic [1:0] SN_NOHIT = 2'd2;
  localparam logic [1:0] SN_RSVD  = 2'd3;

  localparam int RC_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);

  localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(RETRY_GAP);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              live_q;     // low only until the first edge after reset, keeps req_ready at 0 in reset
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        snoop_q;
  logic [RC_W-1:0]   retry_q;
  logic [GAP_W-1:0]  gap_q;

  logic              ack_fire;
  logic [1:0]        snp_map;
  logic              retryable;
  logic              do_retry;

  assign ack_fire  = (state_q == S_ISSUE) && bus_ack;
  assign snp_map   = (snoop_rslt == SN_RSVD) ? SN_NOHIT : snoop_rslt;
  // Only ops that need the line's data can be stuck behind a modified copy.
  assign retryable = (op_q == OP_READ) || (op_q == OP_RWIM);
  assign do_retry  = ack_fire && retryable && (snp_map == SN_HITM) && (retry_q < RC_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    bus_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = live_q;
        if (live_q && req_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus_valid = 1'b1;
        if (bus_ack) begin
          state_d = do_retry ? S_GAP : S_RESP;
        end
      end
      S_GAP: begin
        // Leave when this cycle's decrement brings the counter to zero.
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_ISSUE;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request, retry and gap bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'd0;
      addr_q  <= '0;
      snoop_q <= 2'd0;
      retry_q <= '0;
      gap_q   <= '0;
    end else begin
      if (state_q == S_IDLE && live_q && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr & LINE_MASK;
        retry_q <= '0;
      end
      if (ack_fire) begin
        snoop_q <= snp_map;
        if (do_retry) begin
          retry_q <= retry_q + RC_W'(1);
          gap_q   <= GAP_LOAD;
        end
      end
      if (state_q == S_GAP && gap_q != '0) begin
        gap_q <= gap_q - GAP_W'(1);
      end
    end
  end

  // Bus and response payloads are only meaningful alongside their valids.
  assign bus_op         = bus_valid ? op_q : 2'd0;
  assign bus_addr       = bus_valid ? addr_q : '0;
  assign rsp_snoop      = rsp_valid ? snoop_q : 2'd0;
  assign rsp_retry_fail = rsp_valid && retryable && (snoop_q == SN_HITM) && (retry_q == RC_MAX);

`ifdef BUS_STATS_EN
  logic [15:0] ops_q;
  logic [15:0] hitm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q  <= 16'd0;
      hitm_q <= 16'd0;
    end else if (ack_fire) begin
      if (ops_q != 16'hFFFF) begin
        ops_q <= ops_q + 16'd1;
      end
      if (snp_map == SN_HITM && hitm_q != 16'hFFFF) begin
        hitm_q <= hitm_q + 16'd1;
      end
    end
  end

  assign cnt_ops  = ops_q;
  assign cnt_hitm = hitm_q;
`else
  assign cnt_ops  = 16'd0;
  assign cnt_hitm = 16'd0;
`endif

endmodule

// File: tb/tb_llc_bus_op_ctrl.sv
// tb/tb_llc_bus_op_ctrl.sv - self-checking bench for llc_bus_op_ctrl
`timescale 1ns/1ps
module tb_llc_bus_op_ctrl;

  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [1:0]  snoop_rslt = 2'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_snoop;
  logic        rsp_retry_fail;
  logic [15:0] cnt_ops;
  logic [15:0] cnt_hitm;

  always #5 clk = ~clk;

  llc_bus_op_ctrl #(
    .ADDR_W(32), .LINE_OFF(6), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .snoop_rslt(snoop_rslt),
    .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .rsp_retry_fail(rsp_retry_fail),
    .cnt_ops(cnt_ops), .cnt_hitm(cnt_hitm)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_ops  = 0;
  int exp_hitm = 0;

  // Per-transaction bus script: snoop returned on the i-th issue, and how
  // many cycles the bus stalls before acking that issue.
  logic [1:0] g_snp[5];
  int         g_stall[5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] map_snp(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  task automatic chk_stats(input string tag);
`ifdef BUS_STATS_EN
    chk({tag, "_cnt_ops"}, 32'(cnt_ops), (exp_ops > 65535) ? 32'd65535 : 32'(exp_ops));
    chk({tag, "_cnt_hitm"}, 32'(cnt_hitm), (exp_hitm > 65535) ? 32'd65535 : 32'(exp_hitm));
`else
    chk({tag, "_cnt_ops"}, 32'(cnt_ops), 32'd0);
    chk({tag, "_cnt_hitm"}, 32'(cnt_hitm), 32'd0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_bus_valid"}, 32'(bus_valid), 0);
    chk({tag, "_bus_op"}, 32'(bus_op), 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_snoop"}, 32'(rsp_snoop), 0);
    chk({tag, "_rsp_fail"}, 32'(rsp_retry_fail), 0);
    chk({tag, "_cnt_ops"}, 32'(cnt_ops), 0);
    chk({tag, "_cnt_hitm"}, 32'(cnt_hitm), 0);
  endtask

  // One complete transaction against the g_snp/g_stall bus script.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [31:0] addr);
    logic        rtry;
    logic [1:0]  s;
    logic [1:0]  exp_snoop;
    logic        exp_fail;
    logic [31:0] exp_addr;
    int          exp_issues;
    int          idx, wait_c, gap, k;
    bit          in_issue, ack_prev, got_rsp;

    // Reference: an issue is followed by another only for a HITM on a
    // data-fetching op while fewer than MAX_RETRY reissues have happened.
    rtry = (op == 2'd0) || (op == 2'd3);
    exp_issues = 0;
    do begin
      s = map_snp(g_snp[exp_issues]);
      exp_issues++;
    end while (rtry && s == 2'd1 && exp_issues <= MAX_RETRY);
    exp_snoop = s;
    exp_fail  = rtry && (s == 2'd1);
    exp_addr  = {addr[31:6], 6'd0};

    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    bus_ack   = 1'b0;
    @(negedge clk);

    idx = 0; wait_c = 0; gap = 0;
    in_issue = 0; ack_prev = 0; got_rsp = 0;
    for (int cyc = 0; cyc < 200 && !got_rsp; cyc++) begin
      if (cyc > 0) @(negedge clk);
      // Requests offered while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom_range(0, 3));
      req_addr  = $urandom;
      if (rsp_valid) begin
        chk({tag, "_rsp_after_ack"}, 32'(ack_prev), 1);
        chk({tag, "_issues"}, 32'(idx), 32'(exp_issues));
        chk({tag, "_rsp_snoop"}, 32'(rsp_snoop), 32'(exp_snoop));
        chk({tag, "_rsp_fail"}, 32'(rsp_retry_fail), 32'(exp_fail));
        chk({tag, "_rdy_in_rsp"}, 32'(req_ready), 0);
        chk({tag, "_bus_in_rsp"}, 32'(bus_valid), 0);
        got_rsp   = 1;
        req_valid = 1'b0;
        bus_ack   = 1'b0;
      end else if (bus_valid) begin
        if (!in_issue) begin
          if (idx > 0) chk({tag, "_gap_len"}, 32'(gap), RETRY_GAP);
          else         chk({tag, "_issue_lat"}, 32'(cyc), 0);
          in_issue = 1; wait_c = 0; gap = 0;
        end
        chk({tag, "_bus_addr"}, bus_addr, exp_addr);
        chk({tag, "_bus_op"}, 32'(bus_op), 32'(op));
        chk({tag, "_rdy_busy"}, 32'(req_ready), 0);
        if (idx < 5 && wait_c == g_stall[idx]) begin
          bus_ack    = 1'b1;
          snoop_rslt = g_snp[idx];
          idx++;
          in_issue = 0;
          ack_prev = 1;
        end else begin
          bus_ack    = (idx >= 5);
          snoop_rslt = 2'($urandom_range(0, 3));
          if (idx >= 5) idx++;
          wait_c++;
          ack_prev = (idx > 5);
        end
      end else begin
        if (in_issue) chk({tag, "_bus_valid_held"}, 32'(bus_valid), 1);
        in_issue   = 0;
        gap++;
        ack_prev   = 0;
        // Acks outside an issue must be ignored.
        bus_ack    = 1'($urandom_range(0, 1));
        snoop_rslt = 2'($urandom_range(0, 3));
      end
    end
    if (!got_rsp) chk({tag, "_rsp_timeout"}, 0, 1);

    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 0);
    chk({tag, "_rdy_after"}, 32'(req_ready), 1);
    for (int i = 0; i < exp_issues; i++) begin
      if (map_snp(g_snp[i]) == 2'd1) exp_hitm++;
    end
    exp_ops += exp_issues;
    chk_stats(tag);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin g_snp[i] = 2'd2; g_stall[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);

    // Single WRITE
    g_snp[0] = 2'd2; g_stall[0] = 0;
    run_txn("write", 2'd1, 32'h0000_1234);

    // READ recovered after two HITMs
    g_snp[0] = 2'd1; g_snp[1] = 2'd1; g_snp[2] = 2'd0;
    g_stall[0] = 0; g_stall[1] = 0; g_stall[2] = 0;
    run_txn("read_retry", 2'd0, 32'h8000_0047);

    // RWIM with retry budget exhausted
    for (int i = 0; i < 5; i++) begin g_snp[i] = 2'd1; g_stall[i] = 0; end
    run_txn("rwim_exhaust", 2'd3, 32'hCAFE_F00D);

    // INVALIDATE with HITM is never retried
    run_txn("inv_hitm", 2'd2, 32'h1234_5678);

    // WRITE with HITM is never retried either
    run_txn("write_hitm", 2'd1, 32'h0000_00FF);

    // Stalled bus, reserved snoop reported as NOHIT
    g_snp[0] = 2'd3; g_stall[0] = 10;
    run_txn("stall_rsvd", 2'd0, 32'h4444_4444);

    // Reset mid-operation, during the retry gap
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0BAD_BEEF; bus_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_pre_issue", 32'(bus_valid), 1);
    bus_ack = 1'b1; snoop_rslt = 2'd1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rst_in_gap", 32'(bus_valid), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    exp_ops = 0; exp_hitm = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_rsp", 32'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < RETRY_GAP + 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 0);
      chk("rst_no_bus", 32'(bus_valid), 0);
      chk("rst_rdy", 32'(req_ready), 1);
    end
    chk_stats("rst_stats");

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 5; i++) begin
        g_snp[i]   = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
        g_stall[i] = $urandom_range(0, 3);
      end
      run_txn("rand", 2'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
